frame_pingpong_buf: RTL
=======================

FRAME_PINGPONG_BUF -- requirements
Module: frame_pingpong_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32: pixel width in bits.
REQ-002 SHALL have parameter ROWS, default 240: frame height in pixels.
REQ-003 SHALL have parameter COLS, default 320: frame width in pixels.
REQ-004 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have port wr_valid  in  1: write pixel offered.
REQ-007 SHALL have port wr_data  in  WIDTH: write pixel, raster order (row-major, col fastest).
REQ-008 SHALL have port wr_ready  out  1: write side can accept.
REQ-009 SHALL have port flip_h  in  1: read mirrors columns.
REQ-010 SHALL have port flip_v  in  1: read mirrors rows.
REQ-011 SHALL have port invert  in  1: read outputs bitwise NOT of each pixel.
REQ-012 SHALL have port rd_valid  out  1: rd_data valid.
REQ-013 SHALL have port rd_ready  in  1: consumer accepts.
REQ-014 SHALL have port rd_data  out  WIDTH: output pixel.
REQ-015 SHALL have port rd_last  out  1: rd_data is last pixel of frame.

Function
REQ-016 SHALL hold two banks of ROWS*COLS words; each bank has a full flag; wr_sel and rd_sel are 1-bit bank pointers.
REQ-017 SHALL drive wr_ready = !full[wr_sel], combinationally from registered state.
REQ-018 SHALL write on edges with wr_valid&&wr_ready: bank wr_sel at (wr_row, wr_col); col increments, wraps at COLS-1 to 0 while row increments; row wraps at ROWS-1.
REQ-019 SHALL, on the edge accepting pixel (ROWS-1, COLS-1), set full[wr_sel], toggle wr_sel and clear write counters.
REQ-020 SHALL run read FSM IDLE/READ: IDLE->READ when full[rd_sel]=1; READ->IDLE on the edge where rd_valid&&rd_ready&&rd_last.
REQ-021 SHALL latch flip_h, flip_v, invert on the IDLE->READ edge; input changes during READ SHALL have no effect until the next frame.
REQ-022 SHALL issue a read (one fetch per edge) when in READ, not all pixels issued, and (!rd_valid || rd_ready); fetched address row = flip_v ? ROWS-1-r : r, col = flip_h ? COLS-1-c : c, counters r,c raster as in REQ-018.
REQ-023 SHALL register fetched data to rd_data on the edge after issue, XORed with all-ones if latched invert; rd_valid=1 and rd_last=1 for the final pixel.
REQ-024 SHALL hold rd_data, rd_valid, rd_last stable while rd_valid&&!rd_ready; SHALL clear rd_valid on handshake when no new fetch lands.
REQ-025 SHALL sustain one pixel per clock each side when wr_valid and rd_ready are held high.
REQ-026 SHALL, on the READ->IDLE edge, clear full[rd_sel] and toggle rd_sel; wr_ready for that bank rises next cycle.
REQ-027 SHALL treat write and read completion on the same edge independently (both flags update correctly).
REQ-028 SHALL, with both banks full, hold wr_ready=0; no pixel SHALL be dropped or overwritten.
REQ-029 SHALL give latency: last write accepted at edge E -> rd_valid=1 after edge E+2.

Reset
REQ-030 SHALL, while rst=1, force full[1:0]=0, wr_sel=rd_sel=0, all counters=0, FSM=IDLE, latched modes=0, rd_valid=0, rd_last=0, rd_data=0; wr_ready=1.
REQ-031 SHALL abandon any partial write or read frame on reset; memory contents SHALL be left unchanged.

Verification (ROWS=2, COLS=3, WIDTH=8)
REQ-032 SHALL cover: rst pulse -> rd_valid=0, rd_data=8'h00, rd_last=0, wr_ready=1.
REQ-033 SHALL cover: write 00..05, modes 0, rd_ready=1 -> rd_data 00,01,02,03,04,05 on consecutive cycles, rd_last only with 05, first valid at E+2.
REQ-034 SHALL cover: flip_h=flip_v=invert=1 at frame start, then cleared mid-frame -> FA,FB,FC,FD,FE,FF.
REQ-035 SHALL cover: write 3 frames, rd_ready=0 -> wr_ready=0 after 12 pixels; rd_ready=1 through one full read -> wr_ready=1 cycle after rd_last handshake; third frame reads back intact.
REQ-036 SHALL cover: rd_ready toggled 1,0,0,1 pseudo-randomly -> each pixel output exactly once, in order, stable while stalled.
REQ-037 SHALL cover: rst asserted mid-read (after 3 pixels) -> rd_valid=0 asynchronously; new frame written after release reads back completely.

Source files
------------

// File: rtl/frame_pingpong_buf.sv
// Double-buffered frame store: raster writes fill one bank while the other
// bank is streamed out with optional horizontal/vertical mirroring and inversion.
module frame_pingpong_buf #(
    parameter int WIDTH = 32,
    parameter int ROWS  = 240,
    parameter int COLS  = 320
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             flip_h,
    input  logic             flip_v,
    input  logic             invert,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_last
);

    localparam int DEPTH = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int MW    = $clog2(2 * DEPTH);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       full_reg, full_next;
    logic             wr_sel_reg, rd_sel_reg;
    logic [RW-1:0]    wr_row_reg, rd_row_reg;
    logic [CW-1:0]    wr_col_reg, rd_col_reg;
    logic             issued_all_reg;
    logic             flip_h_reg, flip_v_reg, invert_reg;
    logic             pending_reg, pending_last_reg;
    logic [WIDTH-1:0] mem_q;
    logic             rd_valid_reg, rd_last_reg;
    logic [WIDTH-1:0] rd_data_reg;

    logic [WIDTH-1:0] mem [0:2*DEPTH-1];

    logic          wr_fire, wr_end;
    logic          start, slot_free, rd_end, issue, land, fetch_last;
    logic          eff_flip_h, eff_flip_v;
    logic [RW-1:0] fetch_row;
    logic [CW-1:0] fetch_col;
    logic [MW-1:0] wr_idx, rd_idx;

    assign wr_ready = !full_reg[wr_sel_reg];
    assign wr_fire  = wr_valid && !full_reg[wr_sel_reg];
    assign wr_end   = wr_fire && (wr_row_reg == ROW_MAX) && (wr_col_reg == COL_MAX);

    // The first fetch is issued on the IDLE->READ edge itself, using the live
    // mode inputs, so the first pixel appears two edges after the bank fills.
    assign start      = (state_reg == IDLE) && full_reg[rd_sel_reg];
    assign slot_free  = !rd_valid_reg || rd_ready;
    assign rd_end     = (state_reg == READ) && rd_valid_reg && rd_ready && rd_last_reg;
    assign issue      = start || ((state_reg == READ) && !issued_all_reg &&
                                  (!pending_reg || slot_free));
    assign land       = pending_reg && slot_free;
    assign fetch_last = (rd_row_reg == ROW_MAX) && (rd_col_reg == COL_MAX);

    assign eff_flip_h = start ? flip_h : flip_h_reg;
    assign eff_flip_v = start ? flip_v : flip_v_reg;
    assign fetch_row  = eff_flip_v ? (ROW_MAX - rd_row_reg) : rd_row_reg;
    assign fetch_col  = eff_flip_h ? (COL_MAX - rd_col_reg) : rd_col_reg;

    assign wr_idx = MW'(wr_sel_reg ? DEPTH : 0) + MW'(wr_row_reg) * MW'(COLS) + MW'(wr_col_reg);
    assign rd_idx = MW'(rd_sel_reg ? DEPTH : 0) + MW'(fetch_row) * MW'(COLS) + MW'(fetch_col);

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign rd_last  = rd_last_reg;

    // Storage has no reset; mem_q is a second holding stage behind rd_data.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_idx] <= wr_data;
        end
        if (issue) begin
            mem_q <= mem[rd_idx];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (full_reg[rd_sel_reg]) state_next = READ;
            READ:    if (rd_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Write and read completion touch different banks, so both may land together.
    always_comb begin
        full_next = full_reg;
        if (wr_end) full_next[wr_sel_reg] = 1'b1;
        if (rd_end) full_next[rd_sel_reg] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            full_reg         <= 2'b00;
            wr_sel_reg       <= 1'b0;
            rd_sel_reg       <= 1'b0;
            wr_row_reg       <= '0;
            wr_col_reg       <= '0;
            rd_row_reg       <= '0;
            rd_col_reg       <= '0;
            issued_all_reg   <= 1'b0;
            flip_h_reg       <= 1'b0;
            flip_v_reg       <= 1'b0;
            invert_reg       <= 1'b0;
            pending_reg      <= 1'b0;
            pending_last_reg <= 1'b0;
            rd_valid_reg     <= 1'b0;
            rd_last_reg      <= 1'b0;
            rd_data_reg      <= '0;
        end else begin
            state_reg <= state_next;
            full_reg  <= full_next;
            if (wr_end) wr_sel_reg <= ~wr_sel_reg;
            if (rd_end) rd_sel_reg <= ~rd_sel_reg;

            if (wr_fire) begin
                if (wr_col_reg == COL_MAX) begin
                    wr_col_reg <= '0;
                    wr_row_reg <= (wr_row_reg == ROW_MAX) ? '0 : wr_row_reg + RW'(1);
                end else begin
                    wr_col_reg <= wr_col_reg + CW'(1);
                end
            end

            if (start) begin
                flip_h_reg <= flip_h;
                flip_v_reg <= flip_v;
                invert_reg <= invert;
            end

            if (issue) begin
                if (rd_col_reg == COL_MAX) begin
                    rd_col_reg <= '0;
                    rd_row_reg <= (rd_row_reg == ROW_MAX) ? '0 : rd_row_reg + RW'(1);
                end else begin
                    rd_col_reg <= rd_col_reg + CW'(1);
                end
                issued_all_reg   <= fetch_last;
                pending_last_reg <= fetch_last;
            end
            pending_reg <= issue || (pending_reg && !slot_free);

            if (land) begin
                rd_data_reg  <= mem_q ^ {WIDTH{invert_reg}};
                rd_valid_reg <= 1'b1;
                rd_last_reg  <= pending_last_reg;
            end else if (rd_valid_reg && rd_ready) begin
                rd_valid_reg <= 1'b0;
                rd_last_reg  <= 1'b0;
            end
        end
    end

endmodule
